// File: rtl/uart_dump_pkg.sv
// Shared definitions for the UART VRAM dump path and the RX command parser.
// Holds the frame state encoding, frame byte-order selectors and the default header byte.
package uart_dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR_L,
    ST_ADDR_H,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DATA_L,
    ST_DATA_H,
    ST_SUM,
    ST_DONE
  } dump_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Words go out little-endian: low byte first, then high byte.
  localparam logic LO_BYTE = 1'b0;
  localparam logic HI_BYTE = 1'b1;

  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/uart_vram_dump_if.sv
// VRAM read port plus uart_tx byte handshake used by the dump block.
// The master side is the dump block; the slave side is the RAM/uart_tx pair.
interface uart_vram_dump_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;

  modport master (
    output mem_addr, mem_rd, tx_data, tx_data_valid,
    input  mem_rdata, tx_data_ready
  );

  modport slave (
    input  mem_addr, mem_rd, tx_data, tx_data_valid,
    output mem_rdata, tx_data_ready
  );
endinterface

// File: rtl/uart_vram_dump_tx_slot.sv
// Single-byte output register towards uart_tx: load sets valid, acceptance clears it.
// Valid is purely registered, so tx_data_ready never reaches tx_data_valid combinationally.
module tx_byte_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_data_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  output logic       accepted
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && tx_data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data       = data_q;
  assign tx_data_valid = valid_q;
  assign accepted      = valid_q && tx_data_ready;

endmodule

// File: rtl/uart_vram_dump.sv
// Streams a block of VRAM words out through uart_tx as a framed byte sequence:
// HEADER, addr lo/hi, data lo/hi per word, then an 8-bit checksum of all non-header bytes.
module uart_vram_dump
  import uart_dump_pkg::*;
#(
  parameter logic [7:0] HEADER = DEFAULT_HEADER,
  parameter int         RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_addr,
  input  logic [15:0]              cmd_cnt,
  uart_vram_dump_if.master         bus,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  dump_state_e state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic [1:0]  lat_q, lat_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;

  logic        slot_load;
  logic [7:0]  slot_byte;
  logic [7:0]  tx_data_w;
  logic        tx_valid_w;
  logic        accepted;
  logic        byte_state;

  tx_byte_slot u_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (slot_load),
    .load_data     (slot_byte),
    .tx_data_ready (bus.tx_data_ready),
    .tx_data       (tx_data_w),
    .tx_data_valid (tx_valid_w),
    .accepted      (accepted)
  );

  // A byte state loads its byte into the empty slot on its first cycle, then waits for acceptance.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    sum_d      = sum_q;
    lat_d      = lat_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    slot_byte  = 8'h00;
    byte_state = 1'b0;

    if (accepted && state_q != ST_HDR && state_q != ST_SUM) begin
      sum_d = sum_q + tx_data_w;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_cnt;
          sum_d   = 8'h00;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        byte_state = 1'b1;
        slot_byte  = HEADER;
        if (accepted) state_d = ST_ADDR_L;
      end
      ST_ADDR_L: begin
        byte_state = 1'b1;
        slot_byte  = word_byte(addr_q, LO_BYTE);
        if (accepted) state_d = ST_ADDR_H;
      end
      ST_ADDR_H: begin
        byte_state = 1'b1;
        slot_byte  = word_byte(addr_q, HI_BYTE);
        if (accepted) begin
          mem_addr_d = addr_q;
          mem_rd_d   = 1'b1;
          state_d    = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        lat_d   = 2'd1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          word_d  = bus.mem_rdata;
          state_d = ST_DATA_L;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_DATA_L: begin
        byte_state = 1'b1;
        slot_byte  = word_byte(word_q, LO_BYTE);
        if (accepted) state_d = ST_DATA_H;
      end
      // Termination looks at the count before it is decremented.
      ST_DATA_H: begin
        byte_state = 1'b1;
        slot_byte  = word_byte(word_q, HI_BYTE);
        if (accepted) begin
          if (cnt_q == 16'd0) begin
            state_d = ST_SUM;
          end else begin
            cnt_d      = cnt_q - 16'd1;
            addr_d     = addr_q + 16'd1;
            mem_addr_d = addr_q + 16'd1;
            mem_rd_d   = 1'b1;
            state_d    = ST_RD_REQ;
          end
        end
      end
      ST_SUM: begin
        byte_state = 1'b1;
        slot_byte  = sum_q;
        if (accepted) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    slot_load = byte_state && !tx_valid_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= 16'h0000;
      cnt_q      <= 16'h0000;
      word_q     <= 16'h0000;
      sum_q      <= 8'h00;
      lat_q      <= 2'd0;
      mem_addr_q <= 16'h0000;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      lat_q      <= lat_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.tx_data       = tx_data_w;
  assign bus.tx_data_valid = tx_valid_w;
  assign cmd_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);

endmodule
